// File: rtl/and_output_checker_pkg.sv
// ---------------------------------------------------------------------------
// and_check_pkg
// Shared definitions for the AND-gate output integrity monitor:
//   - state_t    : 2-bit FSM state encoding (also driven out on state_o)
//   - DEF_*      : default values for the monitor parameters
// ---------------------------------------------------------------------------
package and_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_SETTLE_CYCLES   = 4;
    localparam int DEF_MISMATCH_THRESH = 3;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/and_output_checker_if.sv
// ---------------------------------------------------------------------------
// and_output_checker_if
// Bundles the monitor's control, tap and status signals.
//   en, clr_alarm, clr_cnt : control from the system
//   a, b, y                : raw taps on the chip pads (asynchronous to clk)
//   alarm                  : sticky tamper alarm
//   mismatch               : one-cycle pulse per detected mismatch
//   mismatch_cnt           : saturating total-mismatch count
//   state_o                : current FSM state, for debug
// Signalling: there is no valid/ready handshake on this bus. Controls are
// level (en) or single-cycle pulses (clr_*) sampled on the rising clk edge;
// pad taps are free-running and are synchronized inside the monitor; all
// status outputs are registered and change only after a rising clk edge.
// The monitor connects through the slave modport, the system side through
// master.
// ---------------------------------------------------------------------------
interface and_output_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr_alarm;
    logic             clr_cnt;
    logic             a;
    logic             b;
    logic             y;
    logic             alarm;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [1:0]       state_o;

    modport master (
        output en, clr_alarm, clr_cnt, a, b, y,
        input  alarm, mismatch, mismatch_cnt, state_o
    );

    modport slave (
        input  en, clr_alarm, clr_cnt, a, b, y,
        output alarm, mismatch, mismatch_cnt, state_o
    );
endinterface

// File: rtl/and_output_checker_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for one asynchronous single-bit input.
//   clk, rst_n : clock, asynchronous active-low reset (chain clears to 0)
//   i_d        : asynchronous input
//   o_q        : synchronized output, SYNC_STAGES cycles behind i_d
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/and_output_checker.sv
// ---------------------------------------------------------------------------
// and_output_checker
// Runtime integrity monitor for an AND-gate chip. The pads a, b and y are
// synchronized, and once (a,b) has been stable for SETTLE_CYCLES cycles the
// monitor checks y == a & b every cycle. MISMATCH_THRESH consecutive
// mismatches latch a sticky alarm; every mismatch is pulsed and counted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : and_output_checker_if slave (controls, taps, status)
// ---------------------------------------------------------------------------
module and_output_checker
    import and_check_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int MISMATCH_THRESH = DEF_MISMATCH_THRESH,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    and_output_checker_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = $clog2(MISMATCH_THRESH + 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    THRESH      = CW'(MISMATCH_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic w_a_s;
    logic w_b_s;
    logic w_y_s;
    logic w_chg;
    logic w_cmp_mis;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_settle;
    logic [SW-1:0]   w_settle_nxt;
    logic [CW-1:0]   r_consec;
    logic [CW-1:0]   w_consec_nxt;
    logic [CW-1:0]   w_consec_base;
    logic [1:0]      r_ab_prev;
    logic            r_alarm;
    logic            r_mismatch;
    logic [CNT_W-1:0] r_cnt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .rst_n(rst_n), .i_d(bus.a), .o_q(w_a_s)
    );
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .rst_n(rst_n), .i_d(bus.b), .o_q(w_b_s)
    );
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_y (
        .clk(clk), .rst_n(rst_n), .i_d(bus.y), .o_q(w_y_s)
    );

    // Any movement of the synchronized inputs restarts the settle window.
    assign w_chg = ({w_a_s, w_b_s} != r_ab_prev);

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_consec_nxt = r_consec;
        w_cmp_mis    = 1'b0;
        // clr_alarm outside ALARM only wipes the run; a compare in the same
        // cycle then counts from zero.
        w_consec_base = bus.clr_alarm ? '0 : r_consec;

        case (r_state)
            ST_IDLE: begin
                w_consec_nxt = '0;
                if (bus.en) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                w_consec_nxt = w_consec_base;
                if (!bus.en) begin
                    w_state_nxt  = ST_IDLE;
                    w_consec_nxt = '0;
                end else if (w_chg) begin
                    w_settle_nxt = SETTLE_LOAD;
                end else if (r_settle == '0) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_settle_nxt = r_settle - 1'b1;
                end
            end
            ST_CHECK: begin
                w_consec_nxt = w_consec_base;
                if (!bus.en) begin
                    w_state_nxt  = ST_IDLE;
                    w_consec_nxt = '0;
                end else if (w_chg) begin
                    // Inputs moved: y may legitimately be in transit, skip.
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = SETTLE_LOAD;
                end else if (w_y_s != (w_a_s & w_b_s)) begin
                    w_cmp_mis    = 1'b1;
                    w_consec_nxt = (w_consec_base == THRESH) ? THRESH
                                                             : w_consec_base + 1'b1;
                    if (w_consec_nxt == THRESH) begin
                        w_state_nxt = ST_ALARM;
                    end
                end else begin
                    w_consec_nxt = '0;
                end
            end
            ST_ALARM: begin
                if (bus.clr_alarm) begin
                    w_consec_nxt = '0;
                    if (bus.en) begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = SETTLE_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_settle   <= '0;
            r_consec   <= '0;
            r_ab_prev  <= '0;
            r_alarm    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_settle   <= w_settle_nxt;
            r_consec   <= w_consec_nxt;
            r_ab_prev  <= {w_a_s, w_b_s};
            r_alarm    <= (w_state_nxt == ST_ALARM);
            r_mismatch <= w_cmp_mis;
        end
    end

    // Saturating total count; a clear in the same cycle beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_cnt <= '0;
        end else if (w_cmp_mis && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.alarm        = r_alarm;
    assign bus.mismatch     = r_mismatch;
    assign bus.mismatch_cnt = r_cnt;
    assign bus.state_o      = r_state;
endmodule

// File: tb/tb_and_output_checker.sv
// ---------------------------------------------------------------------------
// tb_and_output_checker
// Directed bench for and_output_checker: a default-parameter instance and a
// CNT_W=2 / MISMATCH_THRESH=8 instance sharing clk and rst_n.
// ---------------------------------------------------------------------------
module tb_and_output_checker;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    and_output_checker_if #(.CNT_W(8)) bus1 ();
    and_output_checker_if #(.CNT_W(2)) bus2 ();

    and_output_checker #(
        .SYNC_STAGES(2), .SETTLE_CYCLES(4), .MISMATCH_THRESH(3), .CNT_W(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    and_output_checker #(
        .SYNC_STAGES(2), .SETTLE_CYCLES(4), .MISMATCH_THRESH(8), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic en, input logic a, input logic b, input logic y);
        bus1.en = en;
        bus1.a  = a;
        bus1.b  = b;
        bus1.y  = y;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        logic found;
        logic bad;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        bus1.clr_alarm = 1'b0;
        bus1.clr_cnt   = 1'b0;
        bus2.en = 1'b0; bus2.a = 1'b0; bus2.b = 1'b0; bus2.y = 1'b0;
        bus2.clr_alarm = 1'b0;
        bus2.clr_cnt   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", bus1.state_o, 0);
        check("rst_alarm", bus1.alarm, 0);
        check("rst_mismatch", bus1.mismatch, 0);
        check("rst_cnt", bus1.mismatch_cnt, 0);

        // 1: matching pads held for 50 cycles
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus1.mismatch !== 1'b0) bad = 1'b1;
        end
        check("t1_no_pulse", bad, 0);
        check("t1_state", bus1.state_o, 2);
        check("t1_alarm", bus1.alarm, 0);
        check("t1_cnt", bus1.mismatch_cnt, 0);

        // 4: y = 0,1,0,0,1 while in CHECK with a=b=1
        bus1.y = 1'b0; @(negedge clk);
        bus1.y = 1'b1; @(negedge clk);
        bus1.y = 1'b0; @(negedge clk);
        bus1.y = 1'b0; @(negedge clk);
        bus1.y = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_cnt", bus1.mismatch_cnt, 3);
        check("t4_alarm", bus1.alarm, 0);
        check("t4_state", bus1.state_o, 2);

        // 2: persistent mismatch a=b=1, y=0
        do_reset();
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus1.mismatch === 1'b1) found = 1'b1;
        end
        check("t2_first_pulse_seen", found, 1);
        check("t2_p1_cnt", bus1.mismatch_cnt, 1);
        check("t2_p1_alarm", bus1.alarm, 0);
        @(negedge clk);
        check("t2_p2_pulse", bus1.mismatch, 1);
        check("t2_p2_cnt", bus1.mismatch_cnt, 2);
        check("t2_p2_alarm", bus1.alarm, 0);
        @(negedge clk);
        check("t2_p3_pulse", bus1.mismatch, 1);
        check("t2_p3_cnt", bus1.mismatch_cnt, 3);
        check("t2_alarm", bus1.alarm, 1);
        check("t2_state", bus1.state_o, 3);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.mismatch !== 1'b0 || bus1.mismatch_cnt !== 8'd3 || bus1.alarm !== 1'b1) bad = 1'b1;
        end
        check("t2_hold_20", bad, 0);

        // 5: clr_alarm with en=1, then clr_cnt racing a mismatch compare
        bus1.clr_alarm = 1'b1;
        @(negedge clk);
        bus1.clr_alarm = 1'b0;
        check("t5_alarm_clr", bus1.alarm, 0);
        check("t5_state_settle", bus1.state_o, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus1.state_o === 2'd2) found = 1'b1;
        end
        check("t5_reach_check", found, 1);
        bus1.clr_cnt = 1'b1;
        @(negedge clk);
        bus1.clr_cnt = 1'b0;
        check("t5_pulse_with_clr", bus1.mismatch, 1);
        check("t5_cnt_cleared", bus1.mismatch_cnt, 0);
        @(negedge clk);
        check("t5_cnt_after", bus1.mismatch_cnt, 1);

        // 3: a toggled every 3 cycles keeps the FSM in SETTLE
        do_reset();
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus1.state_o === 2'd2 || bus1.state_o === 2'd3 || bus1.mismatch !== 1'b0) bad = 1'b1;
            if (i % 3 == 2) bus1.a = ~bus1.a;
        end
        check("t3_never_check", bad, 0);
        check("t3_state", bus1.state_o, 1);
        check("t3_cnt", bus1.mismatch_cnt, 0);
        check("t3_alarm", bus1.alarm, 0);

        // 6: CNT_W=2 saturation, then asynchronous reset mid-CHECK
        do_reset();
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        bus2.en = 1'b1; bus2.a = 1'b1; bus2.b = 1'b1; bus2.y = 1'b0;
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus2.mismatch === 1'b1) found = 1'b1;
        end
        check("t6_first_pulse_seen", found, 1);
        @(negedge clk);
        @(negedge clk);
        check("t6_cnt_3rd", bus2.mismatch_cnt, 3);
        @(negedge clk);
        @(negedge clk);
        check("t6_pulse_5th", bus2.mismatch, 1);
        check("t6_cnt_sat", bus2.mismatch_cnt, 3);
        check("t6_alarm", bus2.alarm, 0);
        check("t6_state", bus2.state_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_state", bus2.state_o, 0);
        check("t6_async_alarm", bus2.alarm, 0);
        check("t6_async_mismatch", bus2.mismatch, 0);
        check("t6_async_cnt", bus2.mismatch_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
